// File: rtl/xeng_acc_ctrl.sv
// Integration controller for the X-engine output: windows/integrations, double-buffered
// accumulator controls and readout handshake. Optional bad-window count: XENG_ACC_CTRL_BADWIN_EN.
module xeng_acc_ctrl #(
    parameter int unsigned WORDS_PER_WIN = 2112,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned MCNT_WIDTH    = 48,
    parameter int unsigned ACC_LEN_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic [ACC_LEN_WIDTH-1:0] acc_len,
    input  logic                     sync_in,
    input  logic                     vld_in,
    input  logic                     window_vld_in,
    input  logic [MCNT_WIDTH-1:0]    mcnt_in,
    input  logic                     dump_ack,
    output logic                     acc_we,
    output logic                     acc_first,
    output logic                     acc_last,
    output logic [ADDR_WIDTH-1:0]    acc_addr,
    output logic                     buf_sel,
    output logic                     dump_req,
    output logic                     dump_buf,
    output logic [MCNT_WIDTH-1:0]    dump_mcnt,
    output logic [15:0]              dump_bad_cnt,
    output logic [31:0]              int_cnt,
    output logic                     running,
    output logic                     overrun,
    output logic                     sync_err
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastWord = ADDR_WIDTH'(WORDS_PER_WIN - 1);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]    word_cnt_q;
    logic [ACC_LEN_WIDTH-1:0] win_cnt_q;
    logic [ACC_LEN_WIDTH-1:0] len_q;
    logic [MCNT_WIDTH-1:0]    pend_mcnt_q;
    logic                     dump_evt_q;

    logic                     acc_we_q, acc_first_q, acc_last_q;
    logic [ADDR_WIDTH-1:0]    acc_addr_q;
    logic                     buf_sel_q, dump_req_q, dump_buf_q;
    logic [MCNT_WIDTH-1:0]    dump_mcnt_q;
    logic [31:0]              int_cnt_q;
    logic                     overrun_q, sync_err_q;

    logic                     in_run, enter_run, resync, wr, win_end, int_end, dump_go;
    logic [ADDR_WIDTH-1:0]    word_eff;
    logic [ACC_LEN_WIDTH-1:0] win_eff, len_m1, acc_len_eff;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (arm) state_d = StArmed;
            StArmed: if (sync_in) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    assign in_run      = (state_q == StRun);
    assign enter_run   = (state_q == StArmed) && sync_in;
    // A sync mid-window restarts counting; a coincident word becomes word 0 of window 0.
    assign resync      = in_run && sync_in && (word_cnt_q != '0);
    assign word_eff    = resync ? '0 : word_cnt_q;
    assign win_eff     = resync ? '0 : win_cnt_q;
    assign wr          = in_run && vld_in;
    assign len_m1      = len_q - ACC_LEN_WIDTH'(1);
    assign win_end     = (word_eff == LastWord);
    assign int_end     = win_end && (win_eff == len_m1);
    assign acc_len_eff = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
    // Dump acts one cycle after the last write so buf_sel flips after that write lands.
    assign dump_go     = dump_evt_q && (!dump_req_q || dump_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q  <= '0;
            win_cnt_q   <= '0;
            len_q       <= ACC_LEN_WIDTH'(1);
            pend_mcnt_q <= '0;
            dump_evt_q  <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
            acc_addr_q  <= '0;
            buf_sel_q   <= 1'b0;
            dump_req_q  <= 1'b0;
            dump_buf_q  <= 1'b0;
            dump_mcnt_q <= '0;
            int_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            acc_we_q   <= wr;
            dump_evt_q <= wr && int_end;

            if (enter_run) begin
                len_q      <= acc_len_eff;
                word_cnt_q <= '0;
                win_cnt_q  <= '0;
            end

            if (resync) begin
                sync_err_q <= 1'b1;
                word_cnt_q <= '0;
                win_cnt_q  <= '0;
            end

            if (wr) begin
                acc_addr_q  <= word_eff;
                acc_first_q <= (win_eff == '0);
                acc_last_q  <= (win_eff == len_m1);
                if ((win_eff == '0) && (word_eff == '0)) pend_mcnt_q <= mcnt_in;
                if (win_end) begin
                    word_cnt_q <= '0;
                    if (int_end) begin
                        win_cnt_q <= '0;
                        len_q     <= acc_len_eff;
                    end else begin
                        win_cnt_q <= win_eff + ACC_LEN_WIDTH'(1);
                    end
                end else begin
                    word_cnt_q <= word_eff + ADDR_WIDTH'(1);
                end
            end

            if (dump_evt_q) begin
                if (dump_go) begin
                    dump_req_q  <= 1'b1;
                    dump_buf_q  <= buf_sel_q;
                    dump_mcnt_q <= pend_mcnt_q;
                    buf_sel_q   <= ~buf_sel_q;
                    int_cnt_q   <= int_cnt_q + 32'd1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (dump_ack) begin
                dump_req_q <= 1'b0;
            end
        end
    end

`ifdef XENG_ACC_CTRL_BADWIN_EN
    logic [15:0] bad_cnt_q, dump_bad_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_cnt_q      <= '0;
            dump_bad_cnt_q <= '0;
        end else begin
            if (wr && (word_eff == '0)) begin
                if (win_eff == '0)                       bad_cnt_q <= {15'd0, ~window_vld_in};
                else if (!window_vld_in && (bad_cnt_q != 16'hFFFF)) bad_cnt_q <= bad_cnt_q + 16'd1;
            end
            if (dump_go) dump_bad_cnt_q <= bad_cnt_q;
        end
    end

    assign dump_bad_cnt = dump_bad_cnt_q;
`else
    logic unused_window_vld;
    assign unused_window_vld = window_vld_in;
    assign dump_bad_cnt      = '0;
`endif

    assign acc_we    = acc_we_q;
    assign acc_first = acc_first_q;
    assign acc_last  = acc_last_q;
    assign acc_addr  = acc_addr_q;
    assign buf_sel   = buf_sel_q;
    assign dump_req  = dump_req_q;
    assign dump_buf  = dump_buf_q;
    assign dump_mcnt = dump_mcnt_q;
    assign int_cnt   = int_cnt_q;
    assign running   = in_run;
    assign overrun   = overrun_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_xeng_acc_ctrl.sv
// Directed bench for xeng_acc_ctrl with an 8-word window.
module tb_xeng_acc_ctrl;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst, arm, sync_in, vld_in, window_vld_in, dump_ack;
    logic [31:0] acc_len;
    logic [47:0] mcnt_in;
    logic        acc_we, acc_first, acc_last, buf_sel, dump_req, dump_buf;
    logic [2:0]  acc_addr;
    logic [47:0] dump_mcnt;
    logic [15:0] dump_bad_cnt;
    logic [31:0] int_cnt;
    logic        running, overrun, sync_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit badwin_mode = 1'b0;

    always #5 clk = ~clk;

    xeng_acc_ctrl #(
        .WORDS_PER_WIN (W),
        .ADDR_WIDTH    (3),
        .MCNT_WIDTH    (48),
        .ACC_LEN_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .acc_len       (acc_len),
        .sync_in       (sync_in),
        .vld_in        (vld_in),
        .window_vld_in (window_vld_in),
        .mcnt_in       (mcnt_in),
        .dump_ack      (dump_ack),
        .acc_we        (acc_we),
        .acc_first     (acc_first),
        .acc_last      (acc_last),
        .acc_addr      (acc_addr),
        .buf_sel       (buf_sel),
        .dump_req      (dump_req),
        .dump_buf      (dump_buf),
        .dump_mcnt     (dump_mcnt),
        .dump_bad_cnt  (dump_bad_cnt),
        .int_cnt       (int_cnt),
        .running       (running),
        .overrun       (overrun),
        .sync_err      (sync_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n consecutive words; k0 is the word index within the integration, len its window count.
    task automatic run_words(input int n, input int len, input int k0, input int mcnt_base);
        for (int i = 0; i < n; i++) begin
            int k;
            int win;
            k   = k0 + i;
            win = (k / W) % len;
            vld_in        = 1'b1;
            mcnt_in       = 48'(mcnt_base + i);
            window_vld_in = badwin_mode ? !(win == 1 || win == 2) : 1'b1;
            tick();
            check("we",    acc_we,    1'b1);
            check("addr",  acc_addr,  64'(k % W));
            check("first", acc_first, win == 0);
            check("last",  acc_last,  win == len - 1);
        end
        vld_in        = 1'b0;
        window_vld_in = 1'b1;
    endtask

    task automatic arm_and_sync();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("armed_not_running", running, 1'b0);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("running", running, 1'b1);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; sync_in = 1'b0; vld_in = 1'b0; window_vld_in = 1'b1;
        dump_ack = 1'b0; acc_len = 32'd3; mcnt_in = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_we",      acc_we,    1'b0);
        check("rst_addr",    acc_addr,  3'd0);
        check("rst_req",     dump_req,  1'b0);
        check("rst_bufsel",  buf_sel,   1'b0);
        check("rst_intcnt",  int_cnt,   32'd0);
        check("rst_running", running,   1'b0);
        check("rst_overrun", overrun,   1'b0);
        check("rst_syncerr", sync_err,  1'b0);
        check("rst_mcnt",    dump_mcnt, 48'd0);
        check("rst_bad",     dump_bad_cnt, 16'd0);

        vld_in = 1'b1;
        tick();
        vld_in = 1'b0;
        check("idle_vld_ignored", acc_we, 1'b0);

        // Basic integration of 3 windows
        arm_and_sync();
        run_words(24, 3, 0, 100);
        check("req_not_early", dump_req, 1'b0);
        tick();
        check("d1_req",    dump_req,  1'b1);
        check("d1_buf",    dump_buf,  1'b0);
        check("d1_bufsel", buf_sel,   1'b1);
        check("d1_mcnt",   dump_mcnt, 48'd100);
        check("d1_intcnt", int_cnt,   32'd1);

        // Ack coincides with next dump event
        run_words(24, 3, 0, 200);
        dump_ack = 1'b1;
        tick();
        dump_ack = 1'b0;
        check("d2_req",     dump_req,  1'b1);
        check("d2_buf",     dump_buf,  1'b1);
        check("d2_bufsel",  buf_sel,   1'b0);
        check("d2_overrun", overrun,   1'b0);
        check("d2_intcnt",  int_cnt,   32'd2);
        check("d2_mcnt",    dump_mcnt, 48'd200);

        // No ack: dropped integration
        run_words(24, 3, 0, 300);
        tick();
        check("ov_overrun", overrun,   1'b1);
        check("ov_bufsel",  buf_sel,   1'b0);
        check("ov_buf",     dump_buf,  1'b1);
        check("ov_mcnt",    dump_mcnt, 48'd200);
        check("ov_intcnt",  int_cnt,   32'd2);
        check("ov_req",     dump_req,  1'b1);

        dump_ack = 1'b1;
        tick();
        dump_ack = 1'b0;
        check("ack_clears", dump_req, 1'b0);
        dump_ack = 1'b1;
        tick();
        dump_ack = 1'b0;
        check("stray_ack_req",    dump_req, 1'b0);
        check("stray_ack_intcnt", int_cnt,  32'd2);

        // acc_len = 0 behaves as 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_overrun", overrun, 1'b0);
        acc_len = 32'd0;
        dump_ack = 1'b1;
        arm_and_sync();
        run_words(9, 1, 0, 600);
        check("len0_first_dump", int_cnt, 32'd1);
        run_words(7, 1, 9, 609);
        tick();
        check("len0_second_dump", int_cnt, 32'd2);
        check("len0_overrun",     overrun, 1'b0);
        dump_ack = 1'b0;

        // Sync mid-window discards partial integration
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_len = 32'd3;
        arm_and_sync();
        run_words(5, 3, 0, 700);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("syncerr_set", sync_err, 1'b1);
        run_words(23, 3, 0, 800);
        check("syncerr_no_dump", int_cnt, 32'd0);
        run_words(1, 3, 23, 823);
        tick();
        check("syncerr_req",    dump_req,  1'b1);
        check("syncerr_mcnt",   dump_mcnt, 48'd800);
        check("syncerr_sticky", sync_err,  1'b1);

        // Reset drops a pending dump
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_drop_req",    dump_req, 1'b0);
        check("rst_drop_bufsel", buf_sel,  1'b0);
        check("rst_drop_syncerr", sync_err, 1'b0);

        // Bad windows 1 and 2 of a 4-window integration
        acc_len = 32'd4;
        arm_and_sync();
        badwin_mode = 1'b1;
        run_words(32, 4, 0, 900);
        badwin_mode = 1'b0;
        tick();
        check("bw_req",    dump_req, 1'b1);
        check("bw_intcnt", int_cnt,  32'd1);
`ifdef XENG_ACC_CTRL_BADWIN_EN
        check("bw_bad_cnt", dump_bad_cnt, 16'd2);
`else
        check("bw_bad_cnt", dump_bad_cnt, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
